// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//   Control FSM that sits directly upstream of a 4-bit shift/down-counter stage.
//   1. It searches the serial data stream for the start pattern 1101.
//      Overlapping matches are found.
//   2. It raises shift enable for 4 cycles. The counter stage loads a delay
//      value MSB first during those cycles.
//   3. It runs a prescaled countdown, using the counter's q as feedback.
//   4. It holds done until the user acknowledges.
//   Total counting time is (delay+1)*PRESCALE cycles.
//
// Parameters:
//   PRESCALE     clock cycles per count step (>= 2)
//
// Ports:
//   i_clk        sole clock, rising edge
//   i_reset      synchronous active-high reset
//   i_data       serial input: start pattern, then delay bits
//   i_q          current value of the downstream counter stage
//   i_ack        user acknowledge, only looked at in DONE
//   i_abort      synchronous abort; exists only with TIMER_CTRL_ABORT_EN
//   o_shift_ena  shift enable to the counter stage (B0..B3)
//   o_count_ena  single-cycle decrement enable to the counter stage
//   o_counting   high in COUNT
//   o_done       high in DONE
//
// Optional feature macro: TIMER_CTRL_ABORT_EN (adds i_abort)
// ---------------------------------------------------------------------------
module timer_ctrl #(
  parameter int PRESCALE = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_data,
  input  logic [3:0] i_q,
  input  logic       i_ack,
`ifdef TIMER_CTRL_ABORT_EN
  input  logic       i_abort,
`endif
  output logic       o_shift_ena,
  output logic       o_count_ena,
  output logic       o_counting,
  output logic       o_done
);

  localparam int              PW     = $clog2(PRESCALE);
  localparam logic [PW-1:0]   P_LAST = PW'(PRESCALE - 1);

  typedef enum logic [3:0] {
    ST_S0    = 4'd0,
    ST_S1    = 4'd1,
    ST_S11   = 4'd2,
    ST_S110  = 4'd3,
    ST_B0    = 4'd4,
    ST_B1    = 4'd5,
    ST_B2    = 4'd6,
    ST_B3    = 4'd7,
    ST_COUNT = 4'd8,
    ST_DONE  = 4'd9
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_pcnt;
  logic [PW-1:0]   w_pcnt_next;
  logic            w_terminal;
  logic            w_abort;

`ifdef TIMER_CTRL_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Last prescaler cycle of a count step.
  assign w_terminal = (r_state == ST_COUNT) && (r_pcnt == P_LAST);

  // Next-state logic: pattern search, fixed shift window, countdown, ack wait.
  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = ST_S0;
    end else begin
      case (r_state)
        ST_S0:    w_state_next = i_data ? ST_S1   : ST_S0;
        ST_S1:    w_state_next = i_data ? ST_S11  : ST_S0;
        // A run of 1s keeps the last two 1s, so the match can overlap.
        ST_S11:   w_state_next = i_data ? ST_S11  : ST_S110;
        ST_S110:  w_state_next = i_data ? ST_B0   : ST_S0;
        ST_B0:    w_state_next = ST_B1;
        ST_B1:    w_state_next = ST_B2;
        ST_B2:    w_state_next = ST_B3;
        ST_B3:    w_state_next = ST_COUNT;
        ST_COUNT: begin
          if (w_terminal && (i_q == 4'd0)) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_COUNT;
          end
        end
        ST_DONE: begin
          if (i_ack) begin
            w_state_next = ST_S0;
          end else begin
            w_state_next = ST_DONE;
          end
        end
        default:  w_state_next = ST_S0;
      endcase
    end
  end

  // Prescaler: held at zero outside COUNT, so it is already cleared on entry.
  always_comb begin
    w_pcnt_next = '0;
    if (w_abort) begin
      w_pcnt_next = '0;
    end else if (r_state == ST_COUNT) begin
      if (r_pcnt == P_LAST) begin
        w_pcnt_next = '0;
      end else begin
        w_pcnt_next = r_pcnt + PW'(1);
      end
    end else begin
      w_pcnt_next = '0;
    end
  end

  // State and prescaler registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_S0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pcnt  <= w_pcnt_next;
    end
  end

  // Output decode. count_ena also depends on pcnt and q: the last step
  // (q already 0) ends the count instead of decrementing.
  always_comb begin
    o_shift_ena = 1'b0;
    o_count_ena = 1'b0;
    o_counting  = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_B0, ST_B1, ST_B2, ST_B3: o_shift_ena = 1'b1;
      ST_COUNT: begin
        o_counting  = 1'b1;
        o_count_ena = w_terminal && (i_q != 4'd0);
      end
      ST_DONE:  o_done = 1'b1;
      default: begin
        o_shift_ena = 1'b0;
        o_done      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl with PRESCALE=4 and a behavioural shift/down counter.
module tb_timer_ctrl;

  localparam int P = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       data  = 1'b0;
  logic       ack   = 1'b0;
  logic [3:0] q     = 4'd0;
  logic       shift_ena, count_ena, counting, done;
`ifdef TIMER_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  timer_ctrl #(.PRESCALE(P)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_data      (data),
    .i_q         (q),
    .i_ack       (ack),
`ifdef TIMER_CTRL_ABORT_EN
    .i_abort     (abort),
`endif
    .o_shift_ena (shift_ena),
    .o_count_ena (count_ena),
    .o_counting  (counting),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  // Behavioural model of the downstream shift/down-counter stage.
  always @(posedge clk) begin
    if (shift_ena)      q <= {q[2:0], data};
    else if (count_ena) q <= q - 4'd1;
    else                q <= q;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sends the start pattern (MSB first), then the four delay bits.
  task automatic send_start(input logic [7:0] pat, input int plen, input logic [3:0] d,
                            output int early, output int sh);
    early = 0;
    sh    = 0;
    for (int i = plen - 1; i >= 0; i--) begin
      data = pat[i];
      tick();
      if (i > 0 && shift_ena) early++;
    end
    for (int i = 3; i >= 0; i--) begin
      if (shift_ena) sh++;
      data = d[i];
      tick();
    end
    if (shift_ena) sh++;
  endtask

  // Runs through COUNT while feeding 1101 repeatedly on data.
  task automatic measure(output int cnt, output int pulses, output int bad_gap,
                         output int sh, output int tmo);
    int last;
    int n;
    last = 0; n = 0; cnt = 0; pulses = 0; bad_gap = 0; sh = 0;
    while (!done && n < 200) begin
      if (counting) cnt++;
      if (shift_ena) sh++;
      if (count_ena) begin
        pulses++;
        if (cnt - last != P) bad_gap++;
        last = cnt;
      end
      data = (n % 4 == 2) ? 1'b0 : 1'b1;
      tick();
      n++;
    end
    tmo  = done ? 0 : 1;
    data = 1'b0;
  endtask

  task automatic test_reset;
    int sh;
    reset = 1'b1; data = 1'b1;
    tick(); tick();
    n_checks++;
    if ({shift_ena, count_ena, counting, done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {shift_ena, count_ena, counting, done});
    end
    reset = 1'b0;
    sh = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (shift_ena) sh++;
    end
    n_checks++;
    if (sh !== 0) begin
      n_fail++; $display("FAIL reset_no_shift: got %0d shift cycles expected 0", sh);
    end
  endtask

  task automatic test_no_match;
    int sh;
    logic [5:0] pat;
    reset = 1'b1; tick(); reset = 1'b0;
    pat = 6'b101100;
    sh = 0;
    for (int i = 5; i >= 0; i--) begin
      data = pat[i];
      tick();
      if (shift_ena) sh++;
    end
    n_checks++;
    if (sh !== 0) begin
      n_fail++; $display("FAIL no_match_1011: got %0d shift cycles expected 0", sh);
    end
  endtask

  // Complete run: pattern, delay load, countdown, done hold, acknowledge.
  task automatic test_run(input logic [7:0] pat, input int plen, input logic [3:0] d, input int hold);
    int early, sh, cnt, pulses, bad_gap, sh_cnt, tmo, dn, got, exp;
    exp_q.push_back(0);
    exp_q.push_back(4);
    exp_q.push_back((int'(d) + 1) * P);
    exp_q.push_back(int'(d));
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(hold);
    exp_q.push_back(0);
    exp_q.push_back(0);
    send_start(pat, plen, d, early, sh);
    measure(cnt, pulses, bad_gap, sh_cnt, tmo);
    dn = 0;
    for (int i = 0; i < hold; i++) begin
      data = (i % 4 == 2) ? 1'b0 : 1'b1;
      if (done) dn++;
      tick();
    end
    data = 1'b0;
    ack  = 1'b1;
    tick();
    ack  = 1'b0;
    for (int k = 0; k < 11; k++) begin
      exp = exp_q.pop_front();
      case (k)
        0:  got = early;
        1:  got = sh;
        2:  got = cnt;
        3:  got = pulses;
        4:  got = bad_gap;
        5:  got = sh_cnt;
        6:  got = tmo;
        7:  got = int'(q);
        8:  got = dn;
        9:  got = int'(done);
        default: got = int'(shift_ena);
      endcase
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL run_d%0d_item%0d: got %0d expected %0d", d, k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_count;
    int early, sh;
    send_start(8'b0000_1101, 4, 4'd3, early, sh);
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (counting !== 1'b1) begin
      n_fail++; $display("FAIL midcount_counting: got %b expected 1", counting);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({shift_ena, count_ena, counting, done} !== 4'b0000) begin
      n_fail++; $display("FAIL midcount_reset: got %b expected 0000", {shift_ena, count_ena, counting, done});
    end
    test_run(8'b0000_1101, 4, 4'd2, 1);
  endtask

`ifdef TIMER_CTRL_ABORT_EN
  task automatic test_abort;
    int cnt;
    logic [3:0] pat;
    pat = 4'b1101;
    for (int i = 3; i >= 0; i--) begin data = pat[i]; tick(); end
    data = 1'b1; tick();
    data = 1'b0; tick();
    abort = 1'b1; tick(); abort = 1'b0;
    n_checks++;
    if ({shift_ena, counting} !== 2'b00) begin
      n_fail++; $display("FAIL abort_b2: got %b expected 00", {shift_ena, counting});
    end
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (counting || shift_ena) cnt++;
    end
    n_checks++;
    if (cnt !== 0) begin
      n_fail++; $display("FAIL abort_idle: got %0d active cycles expected 0", cnt);
    end
    for (int i = 3; i >= 0; i--) begin data = pat[i]; tick(); end
    data = 1'b1; tick();
    reset = 1'b1; abort = 1'b1; tick(); reset = 1'b0; abort = 1'b0;
    data = 1'b0;
    n_checks++;
    if ({shift_ena, count_ena, counting, done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_and_abort: got %b expected 0000", {shift_ena, count_ena, counting, done});
    end
    test_run(8'b0000_1101, 4, 4'd1, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_no_match();
    test_run(8'b0001_1101, 5, 4'b0000, 2);
    test_run(8'b0000_1101, 4, 4'b0101, 10);
    test_run(8'b0000_1101, 4, 4'b1111, 0);
    test_reset_mid_count();
`ifdef TIMER_CTRL_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

- Control FSM that sits directly upstream of the 4-bit shift/down-counter stage and drives its `shift_ena` and `count_ena`.
- Sequence:
  - Searches the serial `data` stream for the start pattern 1101.
  - Asserts `shift_ena` for exactly 4 cycles so the counter stage captures a 4-bit delay value, MSB first.
  - Runs a prescaled countdown using the counter stage's `q` as feedback.
  - Raises `done` and holds it until the user acknowledges with `ack`.
- Total counting time is (delay+1)×PRESCALE cycles.

## Interface
- PRESCALE, 1000, clock cycles per count step; legal range ≥2.
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  1  serial input; the pattern is searched here, then the delay bits arrive here.
- q  input  4  current value of the downstream shift/down-counter stage.
- ack  input  1  user acknowledge; sampled only in DONE.
- shift_ena  output  1  shift enable to the counter stage.
- count_ena  output  1  decrement enable to the counter stage; single-cycle pulse.
- counting  output  1  high in the COUNT state.
- done  output  1  high in the DONE state.
- abort  input  1  present only with TIMER_CTRL_ABORT_EN (see Configuration).

## Operation
- States:
  - Pattern search: S0, S1, S11, S110.
  - Shift: B0, B1, B2, B3.
  - COUNT.
  - DONE.
- Pattern search transitions (overlap allowed):
  - S0: data=1 → S1; else stay.
  - S1: 1 → S11; 0 → S0.
  - S11: 1 → S11; 0 → S110.
  - S110: 1 → B0; 0 → S0.
- B0→B1→B2→B3→COUNT are unconditional. `data` is ignored by the FSM in these states.
- COUNT:
  - Prescaler `pcnt` has width $clog2(PRESCALE). It is cleared to 0 on entry, increments every cycle and wraps at PRESCALE-1.
  - Terminal cycle = `pcnt`==PRESCALE-1.
  - Terminal with q≠0: `count_ena`=1 for that cycle and state stays COUNT.
  - Terminal with q==0: `count_ena`=0 and next state is DONE.
- DONE: `done`=1. ack=1 → S0; otherwise stay.
- Outputs are Moore, decoded from state, except `count_ena`, which is decoded from state+`pcnt`+`q`:
  - `shift_ena`=1 only in B0–B3.
  - `counting`=1 only in COUNT.
  - `done`=1 only in DONE.
- Pattern search is suspended in COUNT and DONE: a 1101 on `data` there has no effect.
- ack is ignored outside DONE.
- `q` is treated as an unsigned 4-bit value. The block never writes `q` itself; it only gates the enables.

## Timing
- Reset: state=S0, `pcnt`=0. `shift_ena`, `count_ena`, `counting` and `done` are all 0 in the cycle after reset is sampled high. Reset in any state, including mid-shift or mid-count, aborts immediately with the same result.
- Shift window:
  - The final '1' of 1101 is sampled at edge N.
  - `shift_ena` is high for the cycles following edges N..N+3.
  - The delay bits on `data` must be valid in those 4 cycles, MSB first.
- The first COUNT cycle follows edge N+4. The counter stage holds the full delay value in that cycle.
- COUNT lasts exactly (delay+1)×PRESCALE cycles.
- `count_ena` pulses exactly `delay` times, spaced PRESCALE cycles apart.
- `done` rises the cycle after the final terminal cycle.
- ack high in a DONE cycle → S0 after that edge. `done` is low the following cycle.
- Back-to-back operation: after DONE→S0, a new 1101 is detected normally. Bits sampled while in DONE do not count toward the pattern.

## Configuration
- Macro: TIMER_CTRL_ABORT_EN.
- Defined:
  - Input port `abort` exists.
  - abort=1 in any state forces S0 and `pcnt`=0 on the next edge, with the same result as reset.
  - Priority: reset > abort > normal transitions.
- Undefined: no `abort` port; behaviour is exactly as described above.

## Test plan
All scenarios use PRESCALE=4 with a behavioural model of the shift/down counter attached.
- Reset: assert reset for 2 cycles with data=1 → all outputs 0, state S0, no `shift_ena` afterwards until a 1101 is seen.
- Pattern with overlap: data = 1,1,1,0,1 → `shift_ena` high for exactly 4 cycles starting the cycle after the last '1'. The pattern 1,0,1,1 produces no `shift_ena`.
- Full run with delay 0101 (5):
  - `counting` high for 24 cycles.
  - `count_ena` pulses 5 times, 4 cycles apart.
  - q reaches 0, then `done`=1.
  - With ack held 0 for 10 cycles, `done` stays 1. ack=1 → `done`=0 the next cycle.
- Delay 0000:
  - `counting` high for exactly 4 cycles with zero `count_ena` pulses, then `done`.
  - Delay 1111 gives 64 counting cycles and 15 pulses.
- Reset mid-COUNT (cycle 7 of a delay-3 run) → next cycle all outputs 0. A subsequent 1101 starts a fresh, correct run.
- With TIMER_CTRL_ABORT_EN: abort=1 during B2 → `shift_ena` low the next cycle, state S0, no `counting`. Reset and abort asserted together behave as reset.
